// File: rtl/fp_sqrt_arbiter.sv
`default_nettype none
//==============================================================================
// fp_sqrt_arbiter - round-robin sharing of one sqrt unit between NB_REQ cores,
// with a single-entry valid/ready result slot per core.  Rev 1.0
//==============================================================================
module fp_sqrt_arbiter #(
   parameter int unsigned NB_REQ     = 4,
   parameter int unsigned ID_WIDTH   = $clog2(NB_REQ),
   parameter int unsigned TAG_WIDTH  = 2,
   parameter int unsigned FP_WIDTH   = 32,
   parameter int unsigned RND_WIDTH  = 3,
   parameter int unsigned STAT_WIDTH = 8
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [NB_REQ-1:0]              req_i,
   output logic [NB_REQ-1:0]              gnt_o,
   input  logic [NB_REQ*FP_WIDTH-1:0]     opa_i,
   input  logic [NB_REQ*RND_WIDTH-1:0]    rnd_i,
   input  logic [NB_REQ*TAG_WIDTH-1:0]    tag_i,
   output logic [NB_REQ-1:0]              rvalid_o,
   input  logic [NB_REQ-1:0]              rready_i,
   output logic [NB_REQ*FP_WIDTH-1:0]     rdata_o,
   output logic [NB_REQ*STAT_WIDTH-1:0]   rstatus_o,
   output logic [NB_REQ*TAG_WIDTH-1:0]    rtag_o,
   output logic                           sqrt_en_o,
   output logic [FP_WIDTH-1:0]            sqrt_opa_o,
   output logic [RND_WIDTH-1:0]           sqrt_rnd_o,
   output logic [ID_WIDTH-1:0]            sqrt_tag_o,
   input  logic                           sqrt_ready_i,
   input  logic                           sqrt_valid_i,
   input  logic [FP_WIDTH-1:0]            sqrt_res_i,
   input  logic [STAT_WIDTH-1:0]          sqrt_status_i,
   input  logic [ID_WIDTH-1:0]            sqrt_tag_i,
   output logic                           err_o
);

   typedef enum logic [1:0] {
      SLOT_IDLE = 2'd0,
      SLOT_BUSY = 2'd1,
      SLOT_DONE = 2'd2
   } slot_state_e;

   logic [NB_REQ-1:0]   elig;
   logic [NB_REQ-1:0]   ret_hit;
   logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   logic                err_q, err_d;
   logic                gnt_found;
   logic [ID_WIDTH-1:0] gnt_idx;
   logic [ID_WIDTH:0]   cand;

   // One extra bit on cand so rr_ptr + offset cannot overflow before the wrap.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      gnt_o     = '0;
      cand      = '0;
      if (sqrt_ready_i) begin
         for (int i = 0; i < int'(NB_REQ); i++) begin
            cand = {1'b0, rr_ptr_q} + (ID_WIDTH+1)'(i);
            if (cand >= (ID_WIDTH+1)'(NB_REQ)) begin
               cand = cand - (ID_WIDTH+1)'(NB_REQ);
            end
            if (!gnt_found && elig[cand]) begin
               gnt_found = 1'b1;
               gnt_idx   = cand[ID_WIDTH-1:0];
            end
         end
      end
      if (gnt_found) begin
         gnt_o[gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (gnt_found) begin
         rr_ptr_d = (gnt_idx == ID_WIDTH'(NB_REQ-1)) ? '0 : gnt_idx + ID_WIDTH'(1);
      end
   end

   assign sqrt_en_o = gnt_found;

   always_comb begin
      sqrt_opa_o = '0;
      sqrt_rnd_o = '0;
      sqrt_tag_o = '0;
      if (gnt_found) begin
         sqrt_opa_o = opa_i[gnt_idx*FP_WIDTH +: FP_WIDTH];
         sqrt_rnd_o = rnd_i[gnt_idx*RND_WIDTH +: RND_WIDTH];
         sqrt_tag_o = gnt_idx;
      end
   end

   // A return that matches no live slot (or an out-of-range ID) hits nothing.
   assign err_d = err_q | (sqrt_valid_i & ~|ret_hit);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rr_ptr_q <= '0;
         err_q    <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         err_q    <= err_d;
      end
   end

   assign err_o = err_q;

   for (genvar k = 0; k < NB_REQ; k++) begin : g_slot
      slot_state_e           state_q, state_d;
      logic [TAG_WIDTH-1:0]  tag_q;
      logic [FP_WIDTH-1:0]   res_q;
      logic [STAT_WIDTH-1:0] status_q;

      assign elig[k] = req_i[k] && (state_q == SLOT_IDLE);

      // An IDLE slot being granted this cycle can take its own zero-latency return.
      assign ret_hit[k] = sqrt_valid_i && (sqrt_tag_i == ID_WIDTH'(k)) &&
                          ((state_q == SLOT_BUSY) || ((state_q == SLOT_IDLE) && gnt_o[k]));

      always_comb begin
         state_d = state_q;
         unique case (state_q)
            SLOT_IDLE: if (gnt_o[k])    state_d = ret_hit[k] ? SLOT_DONE : SLOT_BUSY;
            SLOT_BUSY: if (ret_hit[k])  state_d = SLOT_DONE;
            SLOT_DONE: if (rready_i[k]) state_d = SLOT_IDLE;
            default:                    state_d = SLOT_IDLE;
         endcase
      end

      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            state_q  <= SLOT_IDLE;
            tag_q    <= '0;
            res_q    <= '0;
            status_q <= '0;
         end else begin
            state_q <= state_d;
            if (gnt_o[k]) begin
               tag_q <= tag_i[k*TAG_WIDTH +: TAG_WIDTH];
            end
            if (ret_hit[k]) begin
               res_q    <= sqrt_res_i;
               status_q <= sqrt_status_i;
            end
         end
      end

      assign rvalid_o[k]                              = (state_q == SLOT_DONE);
      assign rdata_o[k*FP_WIDTH +: FP_WIDTH]          = res_q;
      assign rstatus_o[k*STAT_WIDTH +: STAT_WIDTH]    = status_q;
      assign rtag_o[k*TAG_WIDTH +: TAG_WIDTH]         = tag_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_fp_sqrt_arbiter.sv
`default_nettype none
//==============================================================================
// tb_fp_sqrt_arbiter - directed and randomized checks against a slot-level model;
// the sqrt unit is a stub with programmable latency.  Rev 1.0
//==============================================================================
module tb_fp_sqrt_arbiter;
   localparam int NB = 4;
   localparam int FW = 32;
   localparam int TW = 2;
   localparam int RW = 3;
   localparam int SW = 8;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic [NB-1:0]    req, gnt, rvalid, rready;
   logic [NB*FW-1:0] opa, rdata;
   logic [NB*RW-1:0] rnd;
   logic [NB*TW-1:0] tag, rtag;
   logic [NB*SW-1:0] rstatus;
   logic             s_en, s_ready, s_valid, err;
   logic [FW-1:0]    s_opa, s_res;
   logic [RW-1:0]    s_rnd;
   logic [IW-1:0]    s_tag, s_tag_ret;
   logic [SW-1:0]    s_status;

   always #5 clk = ~clk;

   fp_sqrt_arbiter #(
      .NB_REQ(NB), .ID_WIDTH(IW), .TAG_WIDTH(TW), .FP_WIDTH(FW),
      .RND_WIDTH(RW), .STAT_WIDTH(SW)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt),
      .opa_i(opa), .rnd_i(rnd), .tag_i(tag),
      .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata),
      .rstatus_o(rstatus), .rtag_o(rtag),
      .sqrt_en_o(s_en), .sqrt_opa_o(s_opa), .sqrt_rnd_o(s_rnd), .sqrt_tag_o(s_tag),
      .sqrt_ready_i(s_ready), .sqrt_valid_i(s_valid), .sqrt_res_i(s_res),
      .sqrt_status_i(s_status), .sqrt_tag_i(s_tag_ret), .err_o(err)
   );

   // Stand-in sqrt function: exact for the directed operands, a fixed scramble otherwise.
   function automatic logic [SW+FW-1:0] ref_sqrt(input logic [FW-1:0] a);
      case (a)
         32'h4080_0000: return {8'h00, 32'h4000_0000};
         32'h4110_0000: return {8'h00, 32'h4040_0000};
         32'hBF80_0000: return {8'h10, 32'h7FC0_0000};
         default:       return {a[31:24] ^ 8'h3C, a ^ 32'h1357_9BDF};
      endcase
   endfunction

   // ---------------- sqrt unit stub ----------------
   int             lat;
   logic           inj_v;
   logic [IW-1:0]  inj_tag;
   logic           pl_v   [1:3];
   logic [FW-1:0]  pl_opa [1:3];
   logic [IW-1:0]  pl_tag [1:3];
   logic           st_v;
   logic [FW-1:0]  st_opa;
   logic [IW-1:0]  st_tag;
   logic [SW+FW-1:0] st_r;

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 1; i <= 3; i++) pl_v[i] <= 1'b0;
      end else begin
         pl_v[1] <= s_en; pl_opa[1] <= s_opa; pl_tag[1] <= s_tag;
         for (int i = 2; i <= 3; i++) begin
            pl_v[i] <= pl_v[i-1]; pl_opa[i] <= pl_opa[i-1]; pl_tag[i] <= pl_tag[i-1];
         end
      end
   end

   always_comb begin
      if (lat == 0) begin
         st_v = s_en; st_opa = s_opa; st_tag = s_tag;
      end else begin
         st_v = pl_v[lat]; st_opa = pl_opa[lat]; st_tag = pl_tag[lat];
      end
      st_r      = ref_sqrt(st_opa);
      s_valid   = st_v | inj_v;
      s_tag_ret = inj_v ? inj_tag : st_tag;
      s_res     = st_r[FW-1:0];
      s_status  = st_r[SW+FW-1:FW];
   end

   // ---------------- reference model ----------------
   logic [NB-1:0] m_busy, m_done;
   logic [TW-1:0] m_tag  [NB];
   logic [FW-1:0] m_res  [NB];
   logic [SW-1:0] m_stat [NB];
   int            m_rr;
   logic          m_err;
   int            tests = 0;
   int            fails = 0;
   int            pick_q;
   logic [NB-1:0] gnt_seen;
   logic          en_seen;

   task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = '0; m_done = '0; m_rr = 0; m_err = 1'b0;
      for (int k = 0; k < NB; k++) begin
         m_tag[k] = '0; m_res[k] = '0; m_stat[k] = '0;
      end
   endtask

   function automatic int model_pick();
      if (!s_ready) return -1;
      for (int i = 0; i < NB; i++) begin
         int k = (m_rr + i) % NB;
         if (req[k] && !m_busy[k] && !m_done[k]) return k;
      end
      return -1;
   endfunction

   // One clock: check the issue side mid-cycle, advance the model, check results.
   task automatic cycle();
      int               p, hit;
      logic             rv, was_rst;
      logic [IW-1:0]    rt;
      logic [NB-1:0]    eg;
      logic [FW-1:0]    eo;
      logic [RW-1:0]    er;
      logic [IW-1:0]    et;
      logic [NB*FW-1:0] md, ed;
      logic [NB*TW-1:0] mt, ett;
      logic [NB*SW-1:0] ms, es;
      #1;
      p = model_pick();
      eg = '0; eo = '0; er = '0; et = '0;
      if (p >= 0) begin
         eg[p] = 1'b1; eo = opa[p*FW +: FW]; er = rnd[p*RW +: RW]; et = IW'(p);
      end
      gnt_seen = gnt;
      en_seen  = s_en;
      chk("gnt", gnt, eg);
      chk("sqrt_en", s_en, |eg);
      chk("sqrt_opa", s_opa, eo);
      chk("sqrt_rnd", s_rnd, er);
      chk("sqrt_tag", s_tag, et);
      rv = s_valid; rt = s_tag_ret; was_rst = !rst_n;
      @(posedge clk);
      hit = -1;
      if (was_rst) begin
         model_reset();
         p = -1;
      end else begin
         if (rv) begin
            if (m_busy[rt] || p == int'(rt)) hit = int'(rt);
            else m_err = 1'b1;
         end
         for (int k = 0; k < NB; k++) if (m_done[k] && rready[k]) m_done[k] = 1'b0;
         if (p >= 0) begin
            m_busy[p] = 1'b1;
            m_tag[p]  = tag[p*TW +: TW];
            {m_stat[p], m_res[p]} = ref_sqrt(opa[p*FW +: FW]);
            m_rr = (p + 1) % NB;
         end
         if (hit >= 0) begin
            m_busy[hit] = 1'b0; m_done[hit] = 1'b1;
         end
      end
      pick_q = p;
      #1;
      md = '0; ed = '0; mt = '0; ett = '0; ms = '0; es = '0;
      for (int k = 0; k < NB; k++) begin
         if (m_done[k] || was_rst) begin
            md[k*FW +: FW] = '1; ed[k*FW +: FW] = m_res[k];
            mt[k*TW +: TW] = '1; ett[k*TW +: TW] = m_tag[k];
            ms[k*SW +: SW] = '1; es[k*SW +: SW] = m_stat[k];
         end
      end
      chk("rvalid", rvalid, m_done);
      chk("err", err, m_err);
      chk("rdata", rdata & md, ed);
      chk("rtag", rtag & mt, ett);
      chk("rstatus", rstatus & ms, es);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = '0; rready = '0;
      cycle();
      rst_n = 1'b1;
   endtask

   function automatic logic [FW-1:0] rand_opa();
      case ($urandom_range(0, 7))
         0:       return 32'h4080_0000;
         1:       return 32'h4110_0000;
         2:       return 32'hBF80_0000;
         default: return $urandom();
      endcase
   endfunction

   task automatic rand_drive();
      for (int k = 0; k < NB; k++) begin
         if (!req[k] || pick_q == k) begin
            req[k] = ($urandom_range(0, 2) != 0);
            opa[k*FW +: FW] = rand_opa();
            rnd[k*RW +: RW] = RW'($urandom_range(0, 4));
            tag[k*TW +: TW] = TW'($urandom_range(0, 3));
         end else if ($urandom_range(0, 7) == 0) begin
            req[k] = 1'b0;
         end
         rready[k] = ($urandom_range(0, 3) != 0);
      end
      s_ready = ($urandom_range(0, 4) != 0);
   endtask

   initial begin
      rst_n = 1'b0; req = '0; opa = '0; rnd = '0; tag = '0; rready = '0;
      s_ready = 1'b1; lat = 0; inj_v = 1'b0; inj_tag = '0; pick_q = -1;
      gnt_seen = '0; en_seen = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rvalid", rvalid, 4'b0000);
      chk("rst_err", err, 1'b0);
      chk("rst_rdata", rdata, '0);
      chk("rst_rtag", rtag, '0);
      chk("rst_rstatus", rstatus, '0);
      chk("rst_gnt", gnt, 4'b0000);
      chk("rst_en", s_en, 1'b0);
      rst_n = 1'b1;

      // single op, zero latency
      req = 4'b0001; opa[31:0] = 32'h4080_0000; rnd[2:0] = 3'd0; tag[1:0] = 2'd2;
      cycle();
      chk("single_gnt", gnt_seen, 4'b0001);
      req = '0;
      chk("single_rvalid", rvalid, 4'b0001);
      chk("single_rdata", rdata[31:0], 32'h4000_0000);
      chk("single_rtag", rtag[1:0], 2'd2);
      rready = 4'b0001;
      cycle();
      chk("single_release", rvalid, 4'b0000);
      rready = '0;

      // round-robin fairness, L=2
      lat = 2;
      do_reset();
      req = 4'b1111; rready = 4'b1111;
      for (int k = 0; k < NB; k++) opa[k*FW +: FW] = $urandom();
      for (int i = 0; i < 8; i++) begin
         cycle();
         chk("rr_order", gnt_seen, 4'b0001 << (i % NB));
      end
      req = '0;
      repeat (6) cycle();

      // backpressure on requester 1
      do_reset();
      req = 4'b1111; rready = 4'b1101; opa[63:32] = 32'h4110_0000;
      repeat (4) cycle();
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("bp_rvalid1", rvalid[1], 1'b1);
         chk("bp_rdata1", rdata[63:32], 32'h4040_0000);
         chk("bp_nogrant1", gnt_seen[1], 1'b0);
      end
      req = '0; rready = 4'b1111;
      repeat (6) cycle();

      // negative operand -> NaN with invalid flag, only on requester 2
      req = 4'b0100; opa[95:64] = 32'hBF80_0000; rready = 4'b1011;
      for (int i = 0; i < 10 && !rvalid[2]; i++) begin
         cycle();
         if (gnt_seen[2]) req[2] = 1'b0;
      end
      chk("nan_rvalid", rvalid, 4'b0100);
      chk("nan_rdata", rdata[95:64], 32'h7FC0_0000);
      chk("nan_nv", rstatus[2*SW+4], 1'b1);
      rready = 4'b1111;
      cycle();

      // sqrt unit not ready
      lat = 1;
      do_reset();
      req = 4'b0001; rready = 4'b1111;
      cycle();
      req = '0;
      repeat (3) cycle();
      s_ready = 1'b0; req = 4'b1111;
      repeat (2) begin
         cycle();
         chk("nr_gnt", gnt_seen, 4'b0000);
         chk("nr_en", en_seen, 1'b0);
      end
      s_ready = 1'b1;
      cycle();
      chk("nr_resume", gnt_seen, 4'b0010);
      req = '0;
      repeat (4) cycle();

      // stray return, then reset mid-operation
      lat = 3;
      inj_v = 1'b1; inj_tag = 2'd2;
      cycle();
      inj_v = 1'b0;
      chk("err_set", err, 1'b1);
      chk("err_drop", rvalid, 4'b0000);
      cycle();
      chk("err_sticky", err, 1'b1);
      req = 4'b0001;
      cycle();
      req = '0;
      cycle();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      chk("rst2_err", err, 1'b0);
      chk("rst2_rvalid", rvalid, 4'b0000);
      repeat (5) cycle();
      chk("rst2_noresp", rvalid, 4'b0000);

      // randomized traffic at each latency
      for (int l = 0; l <= 3; l++) begin
         lat = l;
         do_reset();
         repeat (300) begin
            rand_drive();
            cycle();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fp_sqrt_arbiter.md
Name: fp_sqrt_arbiter

Overview:
- Shares one fp_sqrt_wrapper instance between NB_REQ requesters (cores) in the shared APU cluster.
- Performs round-robin arbitration with a req/gnt handshake and issues at most one operation per cycle to the sqrt unit.
- Carries the requester ID on the sqrt tag path and routes each result back to that requester's single-entry result register, which uses a valid/ready handshake.
- Each requester has at most one operation outstanding.

Parameters:
- NB_REQ, 4: number of requesters, >=2.
- ID_WIDTH, $clog2(NB_REQ): width of the sqrt-side tag (requester ID).
- TAG_WIDTH, 2: per-requester user tag, held locally and returned with the result.
- FP_WIDTH, 32: operand/result width.
- RND_WIDTH, 3: rounding-mode width.
- STAT_WIDTH, 8: sqrt status width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- req_i  in  NB_REQ  per-requester request
- gnt_o  out  NB_REQ  per-requester grant, one-hot or zero
- opa_i  in  NB_REQ*FP_WIDTH  operands; slice k belongs to requester k
- rnd_i  in  NB_REQ*RND_WIDTH  rounding modes
- tag_i  in  NB_REQ*TAG_WIDTH  user tags
- rvalid_o  out  NB_REQ  result valid
- rready_i  in  NB_REQ  result accepted
- rdata_o  out  NB_REQ*FP_WIDTH  results
- rstatus_o  out  NB_REQ*STAT_WIDTH  status flags
- rtag_o  out  NB_REQ*TAG_WIDTH  returned user tags
- sqrt_en_o  out  1  issue to sqrt unit
- sqrt_opa_o  out  FP_WIDTH  operand
- sqrt_rnd_o  out  RND_WIDTH  rounding mode
- sqrt_tag_o  out  ID_WIDTH  requester ID
- sqrt_ready_i  in  1  sqrt unit ready
- sqrt_valid_i  in  1  sqrt result valid
- sqrt_res_i  in  FP_WIDTH  result
- sqrt_status_i  in  STAT_WIDTH  status
- sqrt_tag_i  in  ID_WIDTH  returned requester ID
- err_o  out  1  sticky protocol error

Behaviour:
- Reset:
  - Synchronous, active-low: on a clk_i edge with rst_ni=0, all slots go to IDLE, rr_ptr=0, err_o=0.
  - All result registers, rtag_o and rstatus_o clear to 0.
  - rvalid_o=0. gnt_o and sqrt_en_o are 0 while no slot is eligible.
  - The sqrt unit is reset together with this block. Reset mid-operation discards in-flight work and no response is produced.
- Per-requester slot FSM, states IDLE / BUSY / DONE:
  - IDLE->BUSY on gnt_o[k]; user tag is latched.
  - BUSY->DONE on sqrt_valid_i with sqrt_tag_i==k; sqrt_res_i and sqrt_status_i are latched.
  - DONE->IDLE on rready_i[k].
- Outputs per slot:
  - rvalid_o[k]=1 exactly in DONE.
  - rdata_o, rstatus_o and rtag_o hold stable while in DONE.
- Eligibility: slot in IDLE and req_i[k]=1. A DONE slot with simultaneous rready_i and req_i is not eligible that cycle; it is granted at the earliest the following cycle.
- Arbitration (combinational, same cycle):
  - If sqrt_ready_i=1, grant the first eligible requester scanning k = rr_ptr, rr_ptr+1, ... modulo NB_REQ.
  - If sqrt_ready_i=0 or nothing is eligible, no grant.
  - On a grant to k: rr_ptr <= (k+1) mod NB_REQ; otherwise rr_ptr is unchanged.
- Issue path (combinational, no register inside this block):
  - sqrt_en_o = |gnt_o.
  - sqrt_opa_o, sqrt_rnd_o and sqrt_tag_o are the granted requester's slice.
  - When not issuing, sqrt_opa_o=0, sqrt_rnd_o=0, sqrt_tag_o=0.
- Requester protocol:
  - Operands are stable while req_i=1 and until gnt_o.
  - req_i may drop before grant with no side effect.
- Latency:
  - gnt to sqrt_valid_i is L = the sqrt unit's C_SQRT_PIPE_REGS cycles (L=0 means the same cycle).
  - rvalid_o rises one cycle after sqrt_valid_i, so gnt-to-rvalid = L+1 cycles.
  - Minimum per-requester turnaround is L+2 cycles; aggregate throughput is one issue per cycle.
- Error handling:
  - sqrt_valid_i with sqrt_tag_i >= NB_REQ, or pointing to a slot not in BUSY, is dropped and sets err_o.
  - err_o stays set until reset.
- Simultaneous events:
  - One grant and one return in the same cycle to different slots are both handled.
  - With L=0, a grant and its own return occur in the same cycle: the slot goes IDLE->DONE directly. Implementation: next state is DONE if the return matches, else BUSY.
- Widths: rr_ptr is ID_WIDTH bits; wrap at NB_REQ-1 -> 0, including non-power-of-two NB_REQ.

Test Plan:
- Single op, L=0: req_i=0001, opa=0x40800000 (4.0), rnd=0, tag=2 -> gnt_o=0001 same cycle; next cycle rvalid_o[0]=1, rdata=0x40000000, rtag=2; rready -> rvalid_o[0]=0.
- Round-robin fairness, L=2: all four requesting continuously with immediate rready -> grant order 0,1,2,3 in consecutive cycles; each requester is re-granted only after its DONE->IDLE, and rr_ptr wraps 3->0.
- Backpressure: requester 1 issues 0x41100000 (9.0) with rready_i[1]=0 for 5 cycles -> rvalid_o[1] stays high, rdata=0x40400000 is stable, requester 1 is not re-granted, others are granted normally.
- Special value: opa=0xBF800000 (-1.0) -> rdata is NaN, rstatus invalid flag = 1, routed only to the issuing requester.
- sqrt_ready_i=0 with req_i=1111 -> gnt_o=0000 and sqrt_en_o=0; ready returns -> grant goes to rr_ptr.
- Error/reset: inject sqrt_valid_i with sqrt_tag_i=2 while slot 2 is IDLE -> err_o=1 and the result is dropped; then assert rst_ni=0 for one cycle while slot 0 is BUSY -> all slots IDLE, err_o=0, rvalid_o=0000.
